// File: rtl/eyemon_pkg.sv
// Shared definitions for the eye-monitor Avalon-MM master: slave register map,
// CSR bit positions and the sequencer state encoding.
package eyemon_pkg;

  localparam int unsigned RegCsr    = 0;
  localparam int unsigned RegChaddr = 1;
  localparam int unsigned RegWdaddr = 2;
  localparam int unsigned RegData   = 3;

  localparam int unsigned CsrStartBit = 0;
  localparam int unsigned CsrReadBit  = 1;
  localparam int unsigned CsrChErrBit = 13;
  localparam int unsigned CsrWdErrBit = 14;
  localparam int unsigned CsrBusyBit  = 15;

  localparam int unsigned GapCntWidth  = 8;
  localparam int unsigned PollCntWidth = 10;

  typedef enum logic [3:0] {
    StIdle,
    StPrePoll,
    StPreGap,
    StWrCh,
    StWrWd,
    StWrData,
    StWrCtrl,
    StPoll,
    StPollGap,
    StRdData,
    StResp
  } state_e;

  // Control word that kicks off a slave operation.
  function automatic logic [15:0] csr_start_word(input logic rd);
    logic [15:0] w;
    w              = '0;
    w[CsrStartBit] = 1'b1;
    w[CsrReadBit]  = rd;
    return w;
  endfunction

endpackage

// File: rtl/eyemon_avmm_access.sv
// Single-access Avalon-MM master engine: registers one read or write and holds it
// until the slave drops waitrequest.
module eyemon_avmm_access #(
  parameter int unsigned avmm_addr_width = 16,
  parameter int unsigned avmm_data_width = 16
) (
  input  logic                       i_clk,
  input  logic                       i_resetn,
  input  logic                       i_start,
  input  logic                       i_rd,
  input  logic [avmm_addr_width-1:0] i_addr,
  input  logic [avmm_data_width-1:0] i_wdata,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [avmm_data_width-1:0] o_rdata,
  output logic [avmm_addr_width-1:0] o_avmm_maddress,
  output logic                       o_avmm_mread,
  output logic                       o_avmm_mwrite,
  output logic [avmm_data_width-1:0] o_avmm_mwritedata,
  input  logic [avmm_data_width-1:0] i_avmm_mreaddata,
  input  logic                       i_avmm_mwaitrequest
);

  logic [avmm_addr_width-1:0] maddress_q;
  logic                       mread_q;
  logic                       mwrite_q;
  logic [avmm_data_width-1:0] mwritedata_q;

  assign o_busy  = mread_q | mwrite_q;
  assign o_done  = o_busy & ~i_avmm_mwaitrequest;
  assign o_rdata = i_avmm_mreaddata;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      maddress_q   <= '0;
      mread_q      <= 1'b0;
      mwrite_q     <= 1'b0;
      mwritedata_q <= '0;
    end else if (o_done) begin
      mread_q  <= 1'b0;
      mwrite_q <= 1'b0;
    end else if (i_start && !o_busy) begin
      maddress_q   <= i_addr;
      mread_q      <= i_rd;
      mwrite_q     <= ~i_rd;
      mwritedata_q <= i_rd ? '0 : i_wdata;
    end
  end

  assign o_avmm_maddress   = maddress_q;
  assign o_avmm_mread      = mread_q;
  assign o_avmm_mwrite     = mwrite_q;
  assign o_avmm_mwritedata = mwritedata_q;

endmodule

// File: rtl/eyemon_avmm_master.sv
// Command sequencer: expands one eye-monitor read/write into the slave's
// program / start / poll / fetch access sequence.
module eyemon_avmm_master
  import eyemon_pkg::*;
#(
  parameter int unsigned channel_address_width = 3,
  parameter int unsigned avmm_addr_width       = 16,
  parameter int unsigned avmm_data_width       = 16,
  parameter int unsigned poll_gap              = 4,
  parameter int unsigned poll_limit            = 255
) (
  input  logic                             i_avmm_clk,
  input  logic                             i_resetn,
  input  logic                             i_cmd_valid,
  output logic                             o_cmd_ready,
  input  logic                             i_cmd_read,
  input  logic [channel_address_width-1:0] i_cmd_chaddr,
  input  logic [1:0]                       i_cmd_wdaddr,
  input  logic [15:0]                      i_cmd_wdata,
  output logic                             o_rsp_valid,
  output logic [15:0]                      o_rsp_rdata,
  output logic [2:0]                       o_rsp_status,
  output logic [avmm_addr_width-1:0]       o_avmm_maddress,
  output logic                             o_avmm_mread,
  output logic                             o_avmm_mwrite,
  output logic [avmm_data_width-1:0]       o_avmm_mwritedata,
  input  logic [avmm_data_width-1:0]       i_avmm_mreaddata,
  input  logic                             i_avmm_mwaitrequest
);

  state_e                           state_q, state_d;
  logic [GapCntWidth-1:0]           gap_q, gap_d;
  logic [PollCntWidth-1:0]          poll_cnt_q, poll_cnt_d;
  logic [15:0]                      rsp_rdata_q, rsp_rdata_d;
  logic [2:0]                       rsp_status_q, rsp_status_d;

  logic                             cmd_read_q;
  logic [channel_address_width-1:0] cmd_chaddr_q;
  logic [1:0]                       cmd_wdaddr_q;
  logic [15:0]                      cmd_wdata_q;

  logic                             acc_start;
  logic                             acc_rd;
  logic [avmm_addr_width-1:0]       acc_addr;
  logic [avmm_data_width-1:0]       acc_wdata;
  logic                             acc_busy;
  logic                             acc_done;
  logic [avmm_data_width-1:0]       acc_rdata;

  logic                             cmd_accept;
  logic                             poll_last;
  logic                             slave_busy;
  logic                             slave_err;

  assign cmd_accept = i_cmd_valid && (state_q == StIdle);
  assign poll_last  = (32'(poll_cnt_q) + 32'd1) >= poll_limit;
  assign slave_busy = acc_rdata[CsrBusyBit];
  assign slave_err  = acc_rdata[CsrWdErrBit] | acc_rdata[CsrChErrBit];

  always_ff @(posedge i_avmm_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q      <= StIdle;
      gap_q        <= '0;
      poll_cnt_q   <= '0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
      cmd_read_q   <= 1'b0;
      cmd_chaddr_q <= '0;
      cmd_wdaddr_q <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      poll_cnt_q   <= poll_cnt_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      if (cmd_accept) begin
        cmd_read_q   <= i_cmd_read;
        cmd_chaddr_q <= i_cmd_chaddr;
        cmd_wdaddr_q <= i_cmd_wdaddr;
        cmd_wdata_q  <= i_cmd_wdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    poll_cnt_d   = poll_cnt_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    acc_start    = 1'b0;
    acc_rd       = 1'b0;
    acc_addr     = avmm_addr_width'(RegCsr);
    acc_wdata    = '0;

    case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          state_d      = StPrePoll;
          poll_cnt_d   = '0;
          rsp_rdata_d  = '0;
          rsp_status_d = '0;
        end
      end
      // Slave ignores register writes while an earlier operation is running.
      StPrePoll: begin
        acc_start = ~acc_busy;
        acc_rd    = 1'b1;
        if (acc_done) begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          if (!slave_busy) begin
            state_d = StWrCh;
          end else if (poll_last) begin
            state_d      = StResp;
            rsp_status_d = 3'b100;
          end else begin
            state_d = StPreGap;
            gap_d   = GapCntWidth'(poll_gap);
          end
        end
      end
      StPreGap: begin
        if (gap_q == '0) state_d = StPrePoll;
        else             gap_d   = gap_q - 1'b1;
      end
      StWrCh: begin
        acc_start = ~acc_busy;
        acc_addr  = avmm_addr_width'(RegChaddr);
        acc_wdata = avmm_data_width'(cmd_chaddr_q);
        if (acc_done) state_d = StWrWd;
      end
      StWrWd: begin
        acc_start = ~acc_busy;
        acc_addr  = avmm_addr_width'(RegWdaddr);
        acc_wdata = avmm_data_width'(cmd_wdaddr_q);
        if (acc_done) state_d = cmd_read_q ? StWrCtrl : StWrData;
      end
      StWrData: begin
        acc_start = ~acc_busy;
        acc_addr  = avmm_addr_width'(RegData);
        acc_wdata = avmm_data_width'(cmd_wdata_q);
        if (acc_done) state_d = StWrCtrl;
      end
      StWrCtrl: begin
        acc_start = ~acc_busy;
        acc_wdata = avmm_data_width'(csr_start_word(cmd_read_q));
        if (acc_done) begin
          state_d    = StPoll;
          poll_cnt_d = '0;
        end
      end
      StPoll: begin
        acc_start = ~acc_busy;
        acc_rd    = 1'b1;
        if (acc_done) begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          if (slave_err) begin
            state_d      = StResp;
            rsp_status_d = {1'b0, acc_rdata[CsrWdErrBit], acc_rdata[CsrChErrBit]};
          end else if (slave_busy) begin
            if (poll_last) begin
              state_d      = StResp;
              rsp_status_d = 3'b100;
            end else begin
              state_d = StPollGap;
              gap_d   = GapCntWidth'(poll_gap);
            end
          end else begin
            state_d = cmd_read_q ? StRdData : StResp;
          end
        end
      end
      StPollGap: begin
        if (gap_q == '0) state_d = StPoll;
        else             gap_d   = gap_q - 1'b1;
      end
      StRdData: begin
        acc_start = ~acc_busy;
        acc_rd    = 1'b1;
        acc_addr  = avmm_addr_width'(RegData);
        if (acc_done) begin
          state_d     = StResp;
          rsp_rdata_d = acc_rdata[15:0];
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  eyemon_avmm_access #(
    .avmm_addr_width(avmm_addr_width),
    .avmm_data_width(avmm_data_width)
  ) u_access (
    .i_clk              (i_avmm_clk),
    .i_resetn           (i_resetn),
    .i_start            (acc_start),
    .i_rd               (acc_rd),
    .i_addr             (acc_addr),
    .i_wdata            (acc_wdata),
    .o_busy             (acc_busy),
    .o_done             (acc_done),
    .o_rdata            (acc_rdata),
    .o_avmm_maddress    (o_avmm_maddress),
    .o_avmm_mread       (o_avmm_mread),
    .o_avmm_mwrite      (o_avmm_mwrite),
    .o_avmm_mwritedata  (o_avmm_mwritedata),
    .i_avmm_mreaddata   (i_avmm_mreaddata),
    .i_avmm_mwaitrequest(i_avmm_mwaitrequest)
  );

  assign o_cmd_ready  = (state_q == StIdle);
  assign o_rsp_valid  = (state_q == StResp);
  assign o_rsp_rdata  = rsp_rdata_q;
  assign o_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_eyemon_avmm_master.sv
// Bench for eyemon_avmm_master: behavioural eye-monitor slave plus write and
// response scoreboards fed by directed commands.
module tb_eyemon_avmm_master;

  localparam int unsigned BusyCycles = 30;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_read = 1'b0;
  logic [2:0]  cmd_chaddr = '0;
  logic [1:0]  cmd_wdaddr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [2:0]  rsp_status;
  logic [15:0] maddress;
  logic        mread;
  logic        mwrite;
  logic [15:0] mwritedata;
  logic [15:0] readdata;
  logic        waitreq;

  always #5 clk = ~clk;

  eyemon_avmm_master #(
    .channel_address_width(3),
    .avmm_addr_width      (16),
    .avmm_data_width      (16),
    .poll_gap             (4),
    .poll_limit           (8)
  ) dut (
    .i_avmm_clk         (clk),
    .i_resetn           (resetn),
    .i_cmd_valid        (cmd_valid),
    .o_cmd_ready        (cmd_ready),
    .i_cmd_read         (cmd_read),
    .i_cmd_chaddr       (cmd_chaddr),
    .i_cmd_wdaddr       (cmd_wdaddr),
    .i_cmd_wdata        (cmd_wdata),
    .o_rsp_valid        (rsp_valid),
    .o_rsp_rdata        (rsp_rdata),
    .o_rsp_status       (rsp_status),
    .o_avmm_maddress    (maddress),
    .o_avmm_mread       (mread),
    .o_avmm_mwrite      (mwrite),
    .o_avmm_mwritedata  (mwritedata),
    .i_avmm_mreaddata   (readdata),
    .i_avmm_mwaitrequest(waitreq)
  );

  // Slave model
  logic [15:0] mem [8][2] = '{default: '0};
  logic [2:0]  s_ch = '0;
  logic [1:0]  s_wd = '0;
  logic [15:0] s_data = '0;
  logic        s_wd_err = 1'b0;
  logic        s_op_read = 1'b0;
  int          busy_cnt = 0;
  int          wait_cnt = 0;
  int          wait_n = 0;
  logic        arm_force = 1'b0;
  logic        s_busy;
  logic        acc_done;

  assign s_busy   = (busy_cnt != 0) || arm_force;
  assign waitreq  = (mread || mwrite) && (wait_cnt < wait_n);
  assign acc_done = (mread || mwrite) && !waitreq;

  always_comb begin
    readdata = '0;
    case (maddress)
      16'd0:   readdata = {s_busy, s_wd_err, 14'b0};
      16'd1:   readdata = {13'b0, s_ch};
      16'd2:   readdata = {14'b0, s_wd};
      16'd3:   readdata = s_data;
      default: readdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        if (s_op_read) s_data <= mem[s_ch][s_wd[0]];
        else           mem[s_ch][s_wd[0]] <= s_data;
      end
    end
    if (acc_done) begin
      wait_cnt <= 0;
      if (mwrite && !s_busy) begin
        case (maddress)
          16'd0: if (mwritedata[0]) begin
            s_wd_err  <= (s_wd > 2'd1);
            s_op_read <= mwritedata[1];
            if (s_wd <= 2'd1) busy_cnt <= BusyCycles;
          end
          16'd1:   s_ch   <= mwritedata[2:0];
          16'd2:   s_wd   <= mwritedata[1:0];
          16'd3:   s_data <= mwritedata;
          default: ;
        endcase
      end
    end else if (mread || mwrite) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Scoreboards and counters
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rsp_q[$];
  int          rsp_cnt = 0;
  int          start_cnt = 0;
  int          csr_reads = 0;
  int          data_reads = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor_loop();
    logic        stalled;
    logic [15:0] h_addr;
    logic [15:0] h_data;
    logic [1:0]  h_strb;
    stalled = 1'b0;
    h_addr  = '0;
    h_data  = '0;
    h_strb  = '0;
    forever begin
      @(negedge clk);
      if (mread || mwrite) check("single_strobe", 32'(mread & mwrite), 32'd0);
      if (stalled) begin
        check("stall_addr", 32'(maddress), 32'(h_addr));
        check("stall_wdata", 32'(mwritedata), 32'(h_data));
        check("stall_strobe", 32'({mread, mwrite}), 32'(h_strb));
      end
      stalled = waitreq;
      h_addr  = maddress;
      h_data  = mwritedata;
      h_strb  = {mread, mwrite};
      if (acc_done) begin
        if (mwrite) begin
          if (exp_wr_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL wr_unexpected: observed write %h:%h expected none", maddress, mwritedata);
          end else begin
            check("wr", {maddress, mwritedata}, exp_wr_q.pop_front());
          end
          if (maddress == 16'd0 && mwritedata[0]) begin
            start_cnt++;
            csr_reads  = 0;
            data_reads = 0;
          end
        end else begin
          if (maddress == 16'd0) csr_reads++;
          if (maddress == 16'd3) data_reads++;
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_rsp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rsp_unexpected: observed status %b rdata %h expected none",
                 rsp_status, rsp_rdata);
        end else begin
          check("rsp", {13'b0, rsp_status, rsp_rdata}, exp_rsp_q.pop_front());
        end
      end
    end
  endtask

  task automatic issue(input logic rd, input logic [2:0] ch, input logic [1:0] wd,
                       input logic [15:0] wdata, input logic [2:0] st, input logic [15:0] rdata);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    exp_wr_q.push_back({16'd1, 13'b0, ch});
    exp_wr_q.push_back({16'd2, 14'b0, wd});
    if (!rd) exp_wr_q.push_back({16'd3, wdata});
    exp_wr_q.push_back({16'd0, 14'b0, rd, 1'b1});
    exp_rsp_q.push_back({13'b0, st, rdata});
    cmd_valid  = 1'b1;
    cmd_read   = rd;
    cmd_chaddr = ch;
    cmd_wdaddr = wd;
    cmd_wdata  = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = 16'hDEAD;
    check("cmd_ready_drop", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n0;
    int k;
    n0 = rsp_cnt;
    k  = 0;
    while (rsp_cnt == n0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    tests++;
    assert (rsp_cnt != n0) else begin
      fails++;
      $error("FAIL %s: observed no response in %0d cycles expected one", tag, k);
    end
    check({tag, "_writes_done"}, 32'(exp_wr_q.size()), 32'd0);
  endtask

  task automatic wait_start();
    int n0;
    int k;
    n0 = start_cnt;
    k  = 0;
    while (start_cnt == n0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", 32'(start_cnt != n0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
    check({tag, "_strobes"}, 32'({mread, mwrite}), 32'd0);
    check({tag, "_maddress"}, 32'(maddress), 32'd0);
    check({tag, "_mwritedata"}, 32'(mwritedata), 32'd0);
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Plain write then read-back of the same word
    issue(1'b0, 3'd2, 2'd1, 16'h002A, 3'b000, 16'h0000);
    wait_rsp("write_op");
    issue(1'b1, 3'd2, 2'd1, 16'h0000, 3'b000, 16'h002A);
    wait_rsp("read_op");
    check("read_op_data_reads", 32'(data_reads), 32'd1);

    // Illegal word address is flagged by the slave, no data fetch
    issue(1'b1, 3'd2, 2'd2, 16'h0000, 3'b010, 16'h0000);
    wait_rsp("wd_err");
    check("wd_err_data_reads", 32'(data_reads), 32'd0);

    // Every access stalled by waitrequest
    wait_n = 5;
    issue(1'b0, 3'd2, 2'd1, 16'h0055, 3'b000, 16'h0000);
    wait_rsp("wait_write");
    issue(1'b1, 3'd2, 2'd1, 16'h0000, 3'b000, 16'h0055);
    wait_rsp("wait_read");
    wait_n = 0;

    // Slave stuck busy after start
    issue(1'b0, 3'd1, 2'd0, 16'h0001, 3'b100, 16'h0000);
    wait_start();
    arm_force = 1'b1;
    wait_rsp("timeout");
    check("timeout_polls", 32'(csr_reads), 32'd8);
    arm_force = 1'b0;

    // Reset while polling aborts silently; the next command runs normally
    issue(1'b1, 3'd2, 2'd1, 16'h0000, 3'b000, 16'h0055);
    wait_start();
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    if (exp_rsp_q.size() != 0) void'(exp_rsp_q.pop_back());
    repeat (3) @(negedge clk);
    check("mid_reset_rsp_count", 32'(exp_rsp_q.size()), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    issue(1'b1, 3'd2, 2'd1, 16'h0000, 3'b000, 16'h0055);
    wait_rsp("after_reset");

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eyemon_avmm_master.md
Name: eyemon_avmm_master

Overview:
Avalon-MM master sequencer that drives the eye-monitor register-file slave (ctrlstatus/chaddress/wdaddress/data at word addresses 0-3). Accepts one high-level command (read or write of a per-channel eye-monitor word) and expands it into the slave's multi-access protocol: program registers, start, poll busy, fetch result. Sits between the reconfiguration/calibration controller and the eye-monitor slave in the transceiver reconfig subsystem.

Parameters:
channel_address_width, 3, width of channel address field
avmm_addr_width, 16, master address width
avmm_data_width, 16, read/write data width
poll_gap, 4, idle cycles between successive status polls (0..255)
poll_limit, 255, max status polls per phase before timeout (1..1023)

Ports:
i_avmm_clk  in  1  clock
i_resetn  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  high only in IDLE
i_cmd_read  in  1  1=read op, 0=write op
i_cmd_chaddr  in  channel_address_width  target channel
i_cmd_wdaddr  in  2  word select (0=enable bit, 1=phase step)
i_cmd_wdata  in  16  write data (ignored for reads)
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_rdata  out  16  read result (0 for writes/errors)
o_rsp_status  out  3  {timeout, wd_addr_err, ch_addr_err}
o_avmm_maddress  out  avmm_addr_width  slave word address
o_avmm_mread  out  1  read strobe
o_avmm_mwrite  out  1  write strobe
o_avmm_mwritedata  out  avmm_data_width  write data
i_avmm_mreaddata  in  avmm_data_width  read data
i_avmm_mwaitrequest  in  1  slave stall

Behaviour:
- Reset (async, i_resetn low): state IDLE; o_cmd_ready=1; o_rsp_valid=0; o_rsp_rdata=0; o_rsp_status=0; mread/mwrite=0; maddress=0; mwritedata=0; counters cleared. Reset mid-transaction aborts immediately, no response issued.
- Command accepted when i_cmd_valid & o_cmd_ready; all cmd fields latched that cycle; o_cmd_ready drops the next cycle.
- Avalon rule: address/strobe/writedata registered, held stable while i_avmm_mwaitrequest=1; access completes on the first cycle with mread|mwrite high and waitrequest low; readdata sampled that cycle; strobes deassert the next cycle. Never mread and mwrite together.
- FSM states/transitions:
  IDLE -> PRE_POLL on accept.
  PRE_POLL: read addr 0; bit15 set -> wait poll_gap, re-poll; clear -> WR_CH (slave discards writes while busy).
  WR_CH: write addr 1 = zero-extended chaddr -> WR_WD.
  WR_WD: write addr 2 = wdaddr -> WR_DATA (write op) or WR_CTRL (read op).
  WR_DATA: write addr 3 = wdata -> WR_CTRL.
  WR_CTRL: write addr 0 = {14'b0, read, 1'b1} -> POLL.
  POLL: read addr 0; bit14|bit13 set -> RESP with errors; bit15 set -> gap, re-poll; else -> RD_DATA (read) or RESP (write).
  RD_DATA: read addr 3; capture into o_rsp_rdata -> RESP.
  RESP: o_rsp_valid=1 for exactly one cycle -> IDLE.
- Gap counter: 8-bit down counter loaded with poll_gap after each busy poll; poll_gap=0 re-polls next cycle.
- Poll counter: 10-bit, cleared on entering PRE_POLL and on entering POLL; increments per completed status read; reaching poll_limit with bit15 still set -> RESP with status[2]=1, rdata=0.
- Error status taken from the POLL sample (bit14 -> status[1], bit13 -> status[0]); rdata forced 0.
- o_rsp_rdata/o_rsp_status hold until next RESP; cleared at command accept.
- No response backpressure; caller must sample o_rsp_valid.
- Waitrequest held indefinitely: master waits, no timeout on individual access (timeout counts polls only).

Decomposition:
- Package eyemon_pkg: register word addresses (CSR=0, CHADDR=1, WDADDR=2, DATA=3), CSR bit positions (START=0, READ=1, CH_ERR=13, WD_ERR=14, BUSY=15), FSM state enum.
- Sub-module eyemon_avmm_access: single-access Avalon master engine (start, rd/wr, addr, wdata -> done, rdata), handles waitrequest hold; the main FSM sequences it.

Test Plan:
- Write op ch=2, wd=1, data=0x002A, slave idle -> writes 1:0x0002, 2:0x0001, 3:0x002A, 0:0x0001, polls until busy clear (~64 cycles) -> rsp_valid, status=0, rdata=0.
- Read op ch=2, wd=1 after above -> writes 0:0x0003, polls, reads addr 3 -> rdata=0x002A, status=0.
- Word address 2 -> slave sets bit14 -> rsp status=3'b010, rdata=0, no addr-3 read.
- Slave held busy (bit15 forced) with poll_limit=8 -> exactly 8 post-start polls, rsp status=3'b100.
- waitrequest high 5 cycles on each access -> address/data/strobe stable throughout, single completion each, same end result as first scenario.
- Assert i_resetn low during POLL -> all outputs at reset values asynchronously, no rsp_valid; next command completes normally.
